// File: rtl/systolic_feed_sequencer.sv
// ---------------------------------------------------------------------------
// systolic_feed_sequencer
//
// Sequences one matrix-multiply pass on an N x N systolic array:
//   CLEAR : one-cycle pe_clr to every PE accumulator
//   FEED  : diagonally skewed read enables/addresses for the A row buffers
//           and B column buffers, followed by N-1 drain cycles
//   WRITE : one result row written back per cycle, rows 0..N-1
//   DONE  : one-cycle done pulse back to the host
//
// Ports
//   clk        clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   start      single-cycle request, only honoured in IDLE
//   k_len      reduction length K, sampled with start
//   busy       high in every state except IDLE
//   done       one-cycle completion pulse
//   pe_clr     clears all PE accumulators
//   a_en       bit i = row-i A-buffer read enable
//   a_addr     row-i A-buffer address at [i*KW +: KW]
//   b_en       bit j = column-j B-buffer read enable
//   b_addr     column-j B-buffer address at [j*KW +: KW]
//   out_wr_en  result write strobe
//   out_row    result row being written
//
// Every output is registered: the registers are loaded from the next-state
// and next-counter values, so outputs line up with the state they describe.
// ---------------------------------------------------------------------------
module systolic_feed_sequencer #(
  parameter int N  = 5,
  parameter int KW = 8,
  parameter int RW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [KW-1:0]     k_len,
  output logic              busy,
  output logic              done,
  output logic              pe_clr,
  output logic [N-1:0]      a_en,
  output logic [N*KW-1:0]   a_addr,
  output logic [N-1:0]      b_en,
  output logic [N*KW-1:0]   b_addr,
  output logic              out_wr_en,
  output logic [RW-1:0]     out_row
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [KW:0] C_DRAIN_EXTRA = (KW+1)'(2*N-3);
  localparam logic [KW:0] C_LAST_ROW    = (KW+1)'(N-1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [KW-1:0]     r_k;
  logic [KW-1:0]     w_k_nxt;
  logic [KW:0]       r_cnt;
  logic [KW:0]       w_cnt_nxt;
  logic [KW:0]       w_feed_last;

  logic [KW+1:0]     w_t;
  logic [KW+1:0]     w_k_ext;
  logic [N-1:0]      w_en;
  logic [N*KW-1:0]   w_addr;

  logic              r_busy;
  logic              r_done;
  logic              r_pe_clr;
  logic [N-1:0]      r_a_en;
  logic [N*KW-1:0]   r_a_addr;
  logic [N-1:0]      r_b_en;
  logic [N*KW-1:0]   r_b_addr;
  logic              r_wr_en;
  logic [RW-1:0]     r_row;

  // Final FEED count: K+2N-3 (last enable at K+N-2, then N-1 drain cycles).
  assign w_feed_last = {1'b0, r_k} + C_DRAIN_EXTRA;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, latched K and shared FEED/WRITE counter
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (k_len != '0) begin
            w_state_nxt = S_CLEAR;
            w_k_nxt     = k_len;
          end else begin
            // Empty reduction: nothing to clear, feed or write.
            w_state_nxt = S_DONE;
          end
        end
      end
      S_CLEAR: begin
        w_state_nxt = S_FEED;
        w_cnt_nxt   = '0;
      end
      S_FEED: begin
        if (r_cnt == w_feed_last) begin
          w_state_nxt = S_WRITE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + (KW+1)'(1);
        end
      end
      S_WRITE: begin
        if (r_cnt == C_LAST_ROW) begin
          w_state_nxt = S_DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + (KW+1)'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Skewed lane enables: lane i is active for t in [i, i+K) and reads
  // element t-i. A and B use the identical skew, so one set feeds both.
  // Comparisons are done one bit wider than t so i+K never wraps.
  always_comb begin
    w_en    = '0;
    w_addr  = '0;
    w_t     = {1'b0, w_cnt_nxt};
    w_k_ext = {2'b00, r_k};
    if (w_state_nxt == S_FEED) begin
      for (int i = 0; i < N; i++) begin
        if ((w_t >= (KW+2)'(i)) && (w_t < ((KW+2)'(i) + w_k_ext))) begin
          w_en[i]            = 1'b1;
          // t-i < K <= 2^KW-1, so the low KW bits of the difference are exact.
          w_addr[i*KW +: KW] = w_t[KW-1:0] - KW'(i);
        end
      end
    end
  end

  // Latched K, counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_k      <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pe_clr <= 1'b0;
      r_a_en   <= '0;
      r_a_addr <= '0;
      r_b_en   <= '0;
      r_b_addr <= '0;
      r_wr_en  <= 1'b0;
      r_row    <= '0;
    end else begin
      r_k      <= w_k_nxt;
      r_cnt    <= w_cnt_nxt;
      r_busy   <= (w_state_nxt != S_IDLE);
      r_done   <= (w_state_nxt == S_DONE);
      r_pe_clr <= (w_state_nxt == S_CLEAR);
      r_a_en   <= w_en;
      r_a_addr <= w_addr;
      r_b_en   <= w_en;
      r_b_addr <= w_addr;
      r_wr_en  <= (w_state_nxt == S_WRITE);
      r_row    <= (w_state_nxt == S_WRITE) ? w_cnt_nxt[RW-1:0] : '0;
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign pe_clr    = r_pe_clr;
  assign a_en      = r_a_en;
  assign a_addr    = r_a_addr;
  assign b_en      = r_b_en;
  assign b_addr    = r_b_addr;
  assign out_wr_en = r_wr_en;
  assign out_row   = r_row;

endmodule

// File: tb/tb_systolic_feed_sequencer.sv
// ---------------------------------------------------------------------------
// tb_systolic_feed_sequencer
//
// Scoreboard bench. Each start pushes the per-cycle expected output vector
// of the whole pass (tagged with the cycle it must appear in) plus the
// hand-computed done cycle. A monitor on the falling edge compares every
// cycle: against the queued vector when one is due, otherwise against the
// all-idle vector.
// ---------------------------------------------------------------------------
module tb_systolic_feed_sequencer;

  localparam int N  = 5;
  localparam int KW = 8;
  localparam int RW = 3;

  typedef struct packed {
    logic              busy;
    logic              done;
    logic              pe_clr;
    logic [N-1:0]      a_en;
    logic [N*KW-1:0]   a_addr;
    logic [N-1:0]      b_en;
    logic [N*KW-1:0]   b_addr;
    logic              wr;
    logic [RW-1:0]     row;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t v;
  } sb_t;

  logic            clk;
  logic            rst;
  logic            start;
  logic [KW-1:0]   k_len;
  logic            busy;
  logic            done;
  logic            pe_clr;
  logic [N-1:0]    a_en;
  logic [N*KW-1:0] a_addr;
  logic [N-1:0]    b_en;
  logic [N*KW-1:0] b_addr;
  logic            out_wr_en;
  logic [RW-1:0]   out_row;

  sb_t sb[$];
  int  dq[$];
  int  cyc;
  int  n_checks;
  int  n_pass;
  bit  chk_en;
  bit  end_req;
  bit  end_done;

  systolic_feed_sequencer #(.N(N), .KW(KW), .RW(RW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .k_len     (k_len),
    .busy      (busy),
    .done      (done),
    .pe_clr    (pe_clr),
    .a_en      (a_en),
    .a_addr    (a_addr),
    .b_en      (b_en),
    .b_addr    (b_addr),
    .out_wr_en (out_wr_en),
    .out_row   (out_row)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected trace of one pass started in cycle s (cycle s+n is "cycle n").
  task automatic push_run(input int k, input int s, input int lat);
    obs_t e;
    sb_t  x;
    int   n;
    n = 1;
    dq.push_back(s + lat);
    if (k == 0) begin
      e = '0; e.busy = 1'b1; e.done = 1'b1;
      x.cyc = s + n; x.v = e; sb.push_back(x);
    end else begin
      e = '0; e.busy = 1'b1; e.pe_clr = 1'b1;
      x.cyc = s + n; x.v = e; sb.push_back(x); n++;
      for (int t = 0; t <= k + 2*N - 3; t++) begin
        e = '0; e.busy = 1'b1;
        for (int i = 0; i < N; i++) begin
          if (t >= i && t - i < k) begin
            e.a_en[i] = 1'b1;
            e.b_en[i] = 1'b1;
            e.a_addr[i*KW +: KW] = KW'(t - i);
            e.b_addr[i*KW +: KW] = KW'(t - i);
          end
        end
        x.cyc = s + n; x.v = e; sb.push_back(x); n++;
      end
      for (int r = 0; r < N; r++) begin
        e = '0; e.busy = 1'b1; e.wr = 1'b1; e.row = RW'(r);
        x.cyc = s + n; x.v = e; sb.push_back(x); n++;
      end
      e = '0; e.busy = 1'b1; e.done = 1'b1;
      x.cyc = s + n; x.v = e; sb.push_back(x);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called just after a rising edge: that edge's cycle is "cycle 0".
  task automatic start_run(input int k, input int lat);
    start = 1'b1;
    k_len = KW'(k);
    push_run(k, cyc, lat);
    step(1);
    start = 1'b0;
  endtask

  // Monitor / comparator
  always @(negedge clk) begin
    obs_t  act;
    obs_t  exp_v;
    string tag;
    int    e;
    if (chk_en) begin
      act   = {busy, done, pe_clr, a_en, a_addr, b_en, b_addr, out_wr_en, out_row};
      exp_v = '0;
      tag   = "idle";
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        exp_v = sb[0].v;
        void'(sb.pop_front());
        tag = "trace";
      end
      n_checks++;
      if (act === exp_v) n_pass++;
      else $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, act, exp_v);
      if (done === 1'b1) begin
        n_checks++;
        if (dq.size() == 0) begin
          $display("FAIL done_unexpected cyc=%0d got=done want=no_done", cyc);
        end else begin
          e = dq.pop_front();
          if (e == cyc) n_pass++;
          else $display("FAIL done_cycle got=%0d want=%0d", cyc, e);
        end
      end
    end
    if (end_req && !end_done) begin
      n_checks++;
      if (sb.size() == 0) n_pass++;
      else $display("FAIL trace_left got=%0d want=0", sb.size());
      n_checks++;
      if (dq.size() == 0) n_pass++;
      else $display("FAIL done_missing got=%0d want=0", dq.size());
      end_done = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1);
  end

  initial begin
    n_checks = 0; n_pass = 0;
    chk_en = 1'b0; end_req = 1'b0; end_done = 1'b0;
    rst = 1'b1; start = 1'b0; k_len = '0;
    step(1);
    chk_en = 1'b1;
    step(1);
    rst = 1'b0;
    step(3);

    // Reset for 2 cycles while idle, then a normal K=3 pass.
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
    start_run(3, 18);               // now in cycle 1
    step(4);                         // cycle 5 (FEED)
    start = 1'b1; k_len = 8'd7;      // ignored
    step(1);
    start = 1'b0;
    step(12);                        // cycle 18 (DONE)
    start = 1'b1; k_len = 8'd9;      // ignored
    step(1);                         // cycle 19, first IDLE
    start_run(1, 16);                // accepted: pe_clr next cycle
    step(17);

    // Empty reduction.
    start_run(0, 1);
    step(3);

    // Reset during FEED at t=4 of a K=3 pass, then a fresh K=2 pass.
    start_run(3, 18);                // cycle 1
    step(5);                         // cycle 6, t=4 visible
    rst = 1'b1;
    while (sb.size() > 0 && sb[$].cyc > cyc) void'(sb.pop_back());
    while (dq.size() > 0 && dq[$] > cyc) void'(dq.pop_back());
    step(1);
    rst = 1'b0;
    step(2);
    start_run(2, 17);
    step(18);

    // Longest reduction.
    start_run(255, 270);
    step(272);

    end_req = 1'b1;
    wait (end_done);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
